// File: rtl/writeback_unit_pkg.sv
// Shared widths, writeback-op encodings and FSM state encodings for the writeback stage.
package writeback_unit_pkg;

    localparam int DATA_SIZE     = 32;
    localparam int GPR_SIZE      = 5;
    localparam int OP_WB_SIZE    = 2;
    localparam int WB_STATE_SIZE = 2;

    localparam logic [OP_WB_SIZE-1:0] WB_NONE     = 2'd0;
    localparam logic [OP_WB_SIZE-1:0] WB_REGISTER = 2'd1;
    localparam logic [OP_WB_SIZE-1:0] WB_MEMORY   = 2'd2;

    typedef enum logic [WB_STATE_SIZE-1:0] {
        WB_IDLE      = 2'd0,
        WB_LOAD_WAIT = 2'd1,
        WB_ERROR     = 2'd2
    } wb_state_t;

endpackage

// File: rtl/load_timeout_counter.sv
// Counts wait cycles of an outstanding load; terminal is high once MEM_TIMEOUT-1 cycles have elapsed.
// Latency: terminal is a combinational decode of the registered count. No backpressure.
// Backpressure: none; clear has priority over enable.
module load_timeout_counter #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [7:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign terminal = (count == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results or load data into the register-file write port, 1-cycle latency.
// Backpressure: stall holds upstream while a load is outstanding or after a load timeout (ERROR, exit via reset).
// Optional WRITEBACK_BYPASS_EN mirrors the write port onto fwd_*; otherwise fwd_* are tied to 0.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_SIZE  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_SIZE-1:0]  result,
    input  logic [GPR_SIZE-1:0]   destination,
    input  logic [OP_WB_SIZE-1:0] writeback,
    input  logic [DATA_SIZE-1:0]  mem_data_in,
    input  logic                  mem_valid,
    output logic                  reg_write_en,
    output logic [GPR_SIZE-1:0]   reg_write_addr,
    output logic [DATA_SIZE-1:0]  reg_write_data,
    output logic                  stall,
    output logic                  mem_error,
    output logic [COUNT_SIZE-1:0] retired_count,
    output logic                  fwd_valid,
    output logic [GPR_SIZE-1:0]   fwd_destination,
    output logic [DATA_SIZE-1:0]  fwd_data
);

    wb_state_t             state, state_next;
    logic [GPR_SIZE-1:0]   load_dest;
    logic                  latch_dest;
    logic                  wr_next;
    logic [GPR_SIZE-1:0]   wr_addr_next;
    logic [DATA_SIZE-1:0]  wr_data_next;
    logic                  cnt_clear;
    logic                  cnt_enable;
    logic                  timeout_hit;

    load_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .terminal (timeout_hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= WB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        wr_next      = 1'b0;
        wr_addr_next = destination;
        wr_data_next = result;
        latch_dest   = 1'b0;
        stall        = 1'b0;
        cnt_clear    = 1'b0;
        cnt_enable   = 1'b0;
        case (state)
            WB_IDLE: begin
                cnt_clear = 1'b1;
                // Unknown encodings fall to default and retire nothing.
                case (writeback)
                    WB_REGISTER: wr_next = 1'b1;
                    WB_MEMORY: begin
                        latch_dest = 1'b1;
                        stall      = 1'b1;
                        state_next = WB_LOAD_WAIT;
                    end
                    default: ;
                endcase
            end
            WB_LOAD_WAIT: begin
                cnt_enable   = 1'b1;
                wr_addr_next = load_dest;
                wr_data_next = mem_data_in;
                stall        = 1'b1;
                // Returning data beats the timeout when both land in the same cycle.
                if (mem_valid) begin
                    wr_next    = 1'b1;
                    stall      = 1'b0;
                    state_next = WB_IDLE;
                end else if (timeout_hit) begin
                    state_next = WB_ERROR;
                end
            end
            WB_ERROR: stall = 1'b1;
            default: state_next = WB_IDLE;
        endcase
        if (reset) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reg_write_en   <= 1'b0;
            reg_write_addr <= '0;
            reg_write_data <= '0;
            load_dest      <= '0;
            retired_count  <= '0;
        end else begin
            reg_write_en <= wr_next;
            if (wr_next) begin
                reg_write_addr <= wr_addr_next;
                reg_write_data <= wr_data_next;
                retired_count  <= retired_count + 1'b1;
            end
            if (latch_dest) begin
                load_dest <= destination;
            end
        end
    end

    assign mem_error = (state == WB_ERROR);

`ifdef WRITEBACK_BYPASS_EN
    assign fwd_valid       = reg_write_en;
    assign fwd_destination = reg_write_addr;
    assign fwd_data        = reg_write_data;
`else
    assign fwd_valid       = 1'b0;
    assign fwd_destination = '0;
    assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected writes are queued when stimulus is driven and
// popped by a negedge monitor; directed checks cover stall, timeout, reset and counter wrap.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    localparam int CS = 4;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [DATA_SIZE-1:0]  result;
    logic [GPR_SIZE-1:0]   destination;
    logic [OP_WB_SIZE-1:0] writeback;
    logic [DATA_SIZE-1:0]  mem_data_in;
    logic                  mem_valid;
    logic                  reg_write_en;
    logic [GPR_SIZE-1:0]   reg_write_addr;
    logic [DATA_SIZE-1:0]  reg_write_data;
    logic                  stall;
    logic                  mem_error;
    logic [CS-1:0]         retired_count;
    logic                  fwd_valid;
    logic [GPR_SIZE-1:0]   fwd_destination;
    logic [DATA_SIZE-1:0]  fwd_data;

    always #5 clock = ~clock;

    writeback_unit #(
        .MEM_TIMEOUT (15),
        .COUNT_SIZE  (CS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .result          (result),
        .destination     (destination),
        .writeback       (writeback),
        .mem_data_in     (mem_data_in),
        .mem_valid       (mem_valid),
        .reg_write_en    (reg_write_en),
        .reg_write_addr  (reg_write_addr),
        .reg_write_data  (reg_write_data),
        .stall           (stall),
        .mem_error       (mem_error),
        .retired_count   (retired_count),
        .fwd_valid       (fwd_valid),
        .fwd_destination (fwd_destination),
        .fwd_data        (fwd_data)
    );

    int            checks   = 0;
    int            failures = 0;
    logic [36:0]   sb[$];
    logic [36:0]   mon_e;
    logic [CS-1:0] exp_count;
    bit            mon_on = 1'b0;
    int            stall_hi;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        if (mon_on) begin
            if (reg_write_en === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_write", 64'(reg_write_en), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    exp_count = exp_count + 1'b1;
                    check("wr_addr", 64'(reg_write_addr), 64'(mon_e[36:32]));
                    check("wr_data", 64'(reg_write_data), 64'(mon_e[31:0]));
                    check("retired_count", 64'(retired_count), 64'(exp_count));
`ifdef WRITEBACK_BYPASS_EN
                    check("fwd_valid", 64'(fwd_valid), 64'd1);
                    check("fwd_dest", 64'(fwd_destination), 64'(mon_e[36:32]));
                    check("fwd_data", 64'(fwd_data), 64'(mon_e[31:0]));
`else
                    check("fwd_valid", 64'(fwd_valid), 64'd0);
                    check("fwd_dest", 64'(fwd_destination), 64'd0);
                    check("fwd_data", 64'(fwd_data), 64'd0);
`endif
                end
            end else begin
                check("fwd_valid_idle", 64'(fwd_valid), 64'd0);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        result      = '0;
        destination = '0;
        writeback   = WB_NONE;
        mem_data_in = '0;
        mem_valid   = 1'b0;
        exp_count   = '0;
        cyc(3);
        @(negedge clock);
        check("rst_wr_en", 64'(reg_write_en), 64'd0);
        check("rst_addr", 64'(reg_write_addr), 64'd0);
        check("rst_data", 64'(reg_write_data), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_mem_error", 64'(mem_error), 64'd0);
        check("rst_count", 64'(retired_count), 64'd0);
        check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        cyc();
        reset  = 1'b0;
        mon_on = 1'b1;

        // Plain register write
        writeback   = WB_REGISTER;
        result      = 32'hDEADBEEF;
        destination = 5'd3;
        sb.push_back({5'd3, 32'hDEADBEEF});
        cyc();
        writeback = WB_NONE;
        @(negedge clock);
        check("t1_wr_en", 64'(reg_write_en), 64'd1);
        check("t1_count", 64'(retired_count), 64'd1);
        cyc();

        // Load answered after four wait cycles, dependent instruction behind it
        writeback   = WB_MEMORY;
        destination = 5'd5;
        result      = 32'h0;
        stall_hi    = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (stall) stall_hi++;
            cyc();
        end
        mem_valid   = 1'b1;
        mem_data_in = 32'h1234;
        sb.push_back({5'd5, 32'h1234});
        @(negedge clock);
        check("t2_stall_drop", 64'(stall), 64'd0);
        check("t2_stall_cycles", 64'(stall_hi), 64'd5);
        cyc();
        mem_valid   = 1'b0;
        writeback   = WB_REGISTER;
        destination = 5'd7;
        result      = 32'hAAAA5555;
        sb.push_back({5'd7, 32'hAAAA5555});
        cyc();
        writeback = WB_NONE;
        cyc(2);

        // Load that never returns
        writeback   = WB_MEMORY;
        destination = 5'd9;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            check("t3_stall_wait", 64'(stall), 64'd1);
            check("t3_no_err_yet", 64'(mem_error), 64'd0);
            cyc();
        end
        writeback = WB_NONE;
        @(negedge clock);
        check("t3_mem_error", 64'(mem_error), 64'd1);
        check("t3_stall_err", 64'(stall), 64'd1);
        cyc();
        mem_valid   = 1'b1;
        mem_data_in = 32'hFFFF;
        cyc();
        mem_valid = 1'b0;
        cyc(3);
        @(negedge clock);
        check("t3_err_sticky", 64'(mem_error), 64'd1);
        check("t3_stall_sticky", 64'(stall), 64'd1);
        check("t3_no_late_wr", 64'(reg_write_en), 64'd0);
        cyc();
        reset = 1'b1;
        cyc();
        reset     = 1'b0;
        exp_count = '0;
        @(negedge clock);
        check("t3_err_cleared", 64'(mem_error), 64'd0);
        check("t3_stall_cleared", 64'(stall), 64'd0);
        check("t3_count_cleared", 64'(retired_count), 64'd0);
        cyc();

        // Data arrives on the last allowed wait cycle
        writeback   = WB_MEMORY;
        destination = 5'd12;
        cyc(15);
        mem_valid   = 1'b1;
        mem_data_in = 32'h5A5A;
        writeback   = WB_NONE;
        sb.push_back({5'd12, 32'h5A5A});
        @(negedge clock);
        check("t4_stall_drop", 64'(stall), 64'd0);
        cyc();
        mem_valid = 1'b0;
        cyc(2);
        @(negedge clock);
        check("t4_no_error", 64'(mem_error), 64'd0);
        check("t4_stall_low", 64'(stall), 64'd0);
        cyc();

        // Reset in the middle of a load, then data shows up
        writeback   = WB_MEMORY;
        destination = 5'd20;
        cyc(2);
        reset     = 1'b1;
        writeback = WB_NONE;
        cyc();
        reset       = 1'b0;
        exp_count   = '0;
        mem_valid   = 1'b1;
        mem_data_in = 32'h7777;
        @(negedge clock);
        check("t5_stall", 64'(stall), 64'd0);
        check("t5_wr_en", 64'(reg_write_en), 64'd0);
        check("t5_mem_error", 64'(mem_error), 64'd0);
        check("t5_count", 64'(retired_count), 64'd0);
        check("t5_addr", 64'(reg_write_addr), 64'd0);
        check("t5_data", 64'(reg_write_data), 64'd0);
        cyc();
        mem_valid = 1'b0;
        cyc(2);
        @(negedge clock);
        check("t5_no_write", 64'(reg_write_en), 64'd0);
        cyc();

        // Sixteen back-to-back writes wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            writeback   = WB_REGISTER;
            destination = 5'(i);
            result      = $urandom;
            sb.push_back({5'(i), result});
            cyc();
        end
        writeback = WB_NONE;
        @(negedge clock);
        check("t6_wrap", 64'(retired_count), 64'd0);
        cyc(3);

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
